// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only I-cache, one 32-bit word per line,
// refilled byte-serially over the shared memory bus on a miss.
module inst_cache #(
   parameter  int INDEX_BITS = 4,
   localparam int TAG_BITS   = 30 - INDEX_BITS,
   localparam int LINES      = 1 << INDEX_BITS
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] pc_in,
   output logic        inst_ready_out,
   output logic [31:0] inst_out,
   input  logic        inv_in,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_din
);

   typedef enum logic [1:0] {IDLE, WAIT_GNT, FILL} state_e;

   state_e state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [23:0] buf_q, buf_d;
   logic [29:0] fill_q, fill_d;
   logic        pend_q, pend_d;
   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q [LINES];
   logic [31:0] data_q [LINES];

   logic [INDEX_BITS-1:0] idx, fidx;
   logic [TAG_BITS-1:0]   tg, ftg;
   logic        hit, done;
   logic [1:0]  off;
   logic        unused_pc;

   assign idx       = pc_in[INDEX_BITS+1:2];
   assign tg        = pc_in[31:INDEX_BITS+2];
   assign fidx      = fill_q[INDEX_BITS-1:0];
   assign ftg       = fill_q[29:INDEX_BITS];
   assign unused_pc = ^pc_in[1:0];

   assign hit = (state_q == IDLE) && valid_q[idx]
             && (tag_q[idx] == tg) && !inv_in;
   assign inst_ready_out = hit;
   assign inst_out       = data_q[idx];

   assign done = (state_q == FILL) && (cnt_q == 3'd4);
   // Address walks base..base+3, then stays on the last byte
   assign off  = (cnt_q > 3'd3) ? 2'd3 : cnt_q[1:0];

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
      end else if (rdy_in) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (!hit && !inv_in) state_d = WAIT_GNT;
         WAIT_GNT: if (mem_gnt) state_d = FILL;
         FILL:     if (cnt_q == 3'd4) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      mem_addr = '0;
      unique case (state_q)
         WAIT_GNT: begin
            mem_req  = 1'b1;
            mem_addr = {fill_q, 2'b00};
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {fill_q, off};
         end
         default: ;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
      pend_d  = pend_q;
      valid_d = valid_q;
      if (inv_in) valid_d = '0;
      unique case (state_q)
         IDLE: begin
            if (!hit && !inv_in) fill_d = pc_in[31:2];
         end
         WAIT_GNT: begin
            if (inv_in) pend_d = 1'b1;
            if (mem_gnt) cnt_d = 3'd0;
         end
         FILL: begin
            if (inv_in) pend_d = 1'b1;
            cnt_d = cnt_q + 3'd1;
            case (cnt_q)
               3'd1:    buf_d[7:0]   = mem_din;
               3'd2:    buf_d[15:8]  = mem_din;
               3'd3:    buf_d[23:16] = mem_din;
               default: ;
            endcase
            if (done) begin
               cnt_d  = 3'd0;
               pend_d = 1'b0;
               // An invalidate seen during the refill leaves the line unusable
               valid_d[fidx] = !(pend_q || inv_in);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cnt_q   <= 3'd0;
         buf_q   <= '0;
         fill_q  <= '0;
         pend_q  <= 1'b0;
         valid_q <= '0;
      end else if (rdy_in) begin
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in && rdy_in && done) begin
         data_q[fidx] <= {mem_din, buf_q};
         tag_q[fidx]  <= ftg;
      end
   end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: scoreboard bench for inst_cache with a byte-wide
// RAM model and a grant-delay arbiter model.
module tb_inst_cache;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] pc_in;
   logic        inst_ready_out;
   logic [31:0] inst_out;
   logic        inv_in;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic [7:0]  mem_din;

   int n_checks = 0;
   int n_errors = 0;
   int gnt_delay = 0;
   int wcnt = 0;
   logic [31:0] sb_q [$];

   always #5 clk_in = ~clk_in;

   inst_cache #(.INDEX_BITS(4)) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .rdy_in(rdy_in),
      .pc_in(pc_in),
      .inst_ready_out(inst_ready_out),
      .inst_out(inst_out),
      .inv_in(inv_in),
      .mem_req(mem_req),
      .mem_gnt(mem_gnt),
      .mem_addr(mem_addr),
      .mem_din(mem_din)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[31:2], 2'b00} * 32'h9E37_79B1 + 32'h0000_0013;
   endfunction

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      logic [31:0] w;
      int sh;
      w  = word_at(a);
      sh = 8 * int'(a[1:0]);
      return 8'(w >> sh);
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock: RAM answers last cycle's address, arbiter reacts
   task automatic cyc();
      logic [31:0] a;
      logic r;
      a = mem_addr;
      r = rdy_in;
      @(posedge clk_in);
      #1;
      if (r) mem_din = ram_byte(a);
      if (!mem_req) begin
         wcnt = 0;
         mem_gnt = 1'b0;
      end else if (!mem_gnt) begin
         if (wcnt >= gnt_delay) mem_gnt = 1'b1;
         else wcnt++;
      end
   endtask

   task automatic step(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk_in);
         cyc();
      end
   endtask

   task automatic fetch(input logic [31:0] pc, input int lat,
                        input bit chk_req);
      int n;
      bit got;
      logic [31:0] e;
      pc_in = pc;
      sb_q.push_back(word_at(pc));
      n = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         @(negedge clk_in);
         if (chk_req && n == 0) check("req_idle", 32'(mem_req), 32'd0);
         if (chk_req && n == 1) begin
            check("req_miss", 32'(mem_req), 32'd1);
            check("addr_miss", mem_addr, {pc[31:2], 2'b00});
         end
         if (inst_ready_out) begin
            e = sb_q.pop_front();
            check("inst", inst_out, e);
            check("req_on_hit", 32'(mem_req), 32'd0);
            if (lat >= 0) check("latency", 32'(n), 32'(lat));
            got = 1'b1;
         end else begin
            n++;
         end
         cyc();
      end
      if (!got) begin
         check("timeout", 32'd0, 32'd1);
         e = sb_q.pop_front();
      end
   endtask

   initial begin
      rst_in  = 1'b0;
      rdy_in  = 1'b1;
      pc_in   = 32'h0;
      inv_in  = 1'b0;
      mem_gnt = 1'b0;
      mem_din = 8'h0;
      step(3);
      @(negedge clk_in);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_ready", 32'(inst_ready_out), 32'd0);
      cyc();
      rst_in = 1'b1;

      // cold misses then sequential hits
      fetch(32'h0, 7, 1'b1);
      fetch(32'h4, 7, 1'b1);
      fetch(32'h0, 0, 1'b0);
      fetch(32'h4, 0, 1'b0);

      // same-index conflict
      fetch(32'h40, 7, 1'b1);
      fetch(32'h0, 7, 1'b1);
      fetch(32'h4, 0, 1'b0);

      // grant delayed five cycles
      gnt_delay = 5;
      pc_in = 32'h208;
      @(negedge clk_in);
      check("dly_ready", 32'(inst_ready_out), 32'd0);
      check("dly_req0", 32'(mem_req), 32'd0);
      cyc();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_in);
         check("dly_req", 32'(mem_req), 32'd1);
         check("dly_addr", mem_addr, 32'h208);
         cyc();
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         check("fill_req", 32'(mem_req), 32'd1);
         check("fill_addr", mem_addr, 32'h208 + 32'(i > 3 ? 3 : i));
         cyc();
      end
      fetch(32'h208, 0, 1'b0);
      gnt_delay = 0;

      // pc changes mid-fill: original line completes first
      pc_in = 32'h100;
      step(3);
      fetch(32'h144, 11, 1'b0);
      fetch(32'h100, 0, 1'b0);
      fetch(32'h4, 7, 1'b1);

      // invalidate during FILL
      pc_in = 32'h80;
      step(4);
      inv_in = 1'b1;
      step(1);
      inv_in = 1'b0;
      fetch(32'h80, 9, 1'b0);
      fetch(32'h4, 7, 1'b1);

      // invalidate in the completing cycle
      pc_in = 32'hC0;
      step(6);
      inv_in = 1'b1;
      step(1);
      inv_in = 1'b0;
      fetch(32'hC0, 7, 1'b1);
      fetch(32'hC0, 0, 1'b0);

      // invalidate in IDLE with a hit present
      inv_in = 1'b1;
      @(negedge clk_in);
      check("inv_hit", 32'(inst_ready_out), 32'd0);
      cyc();
      inv_in = 1'b0;
      fetch(32'hC0, 7, 1'b1);

      // rdy_in low mid-FILL
      pc_in = 32'h10C;
      step(4);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         check("frz_req", 32'(mem_req), 32'd1);
         check("frz_addr", mem_addr, 32'h10E);
         check("frz_ready", 32'(inst_ready_out), 32'd0);
         cyc();
      end
      rdy_in = 1'b1;
      fetch(32'h10C, 3, 1'b0);

      // reset mid-FILL aborts the fill and drops every line
      pc_in = 32'h14;
      step(4);
      rst_in = 1'b0;
      step(1);
      rst_in = 1'b1;
      fetch(32'h14, 7, 1'b1);
      fetch(32'h10C, 7, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
